// File: rtl/rob_multi_port_pkg.sv
// Shared types and default sizes for the multi-port reorder buffer.
package rob_multi_port_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_PREG_W = 6;
  localparam int unsigned ROB_XLEN   = 32;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [ROB_XLEN-1:0]   pc;
    logic [ROB_PREG_W-1:0] rd;
    logic [ROB_PREG_W-1:0] rd_old;
    logic [ROB_XLEN-1:0]   result;
    logic                  regwrite;
  } rob_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [ROB_PREG_W-1:0] preg;
    logic [ROB_XLEN-1:0]   val;
  } rob_fwd_t;

endpackage

// File: rtl/rob_retire_select.sv
// In-order retire-lane selection: lane j retires only if all older lanes do and its entry is done.
module rob_retire_select #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned RET_W = 2,
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0] head,
  input  logic [IDX_W:0]   count,
  input  logic [DEPTH-1:0] ent_valid,
  input  logic [DEPTH-1:0] ent_done,
  output logic [RET_W-1:0] sel_valid,
  output logic [IDX_W:0]   sel_cnt
);

  logic             chain;
  logic [IDX_W-1:0] slot;

  always_comb begin
    sel_valid = '0;
    sel_cnt   = '0;
    chain     = 1'b1;
    slot      = '0;
    for (int j = 0; j < RET_W; j++) begin
      slot = head + IDX_W'(j);
      if (chain && (count > (IDX_W+1)'(j)) && ent_valid[slot] && ent_done[slot]) begin
        sel_valid[j] = 1'b1;
        sel_cnt      = sel_cnt + (IDX_W+1)'(1);
      end else begin
        chain = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_port.sv
// Multi-port reorder buffer: DISP_W-wide dispatch, CPL_W completion/forwarding ports, RET_W retire.
// Optional ROB_FLUSH_EN adds flush/flush_idx to squash entries younger than flush_idx.
module rob_multi_port
  import rob_multi_port_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned DISP_W = 2,
  parameter int unsigned CPL_W  = 3,
  parameter int unsigned RET_W  = 2,
  parameter int unsigned PREG_W = ROB_PREG_W,
  parameter int unsigned XLEN   = ROB_XLEN,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DISP_W-1:0]        disp_valid,
  input  logic [DISP_W*XLEN-1:0]   disp_pc,
  input  logic [DISP_W*PREG_W-1:0] disp_rd,
  input  logic [DISP_W*PREG_W-1:0] disp_rd_old,
  input  logic [DISP_W-1:0]        disp_regwrite,
  output logic                     disp_ready,
  output logic [DISP_W*IDX_W-1:0]  disp_idx,
  input  logic [CPL_W-1:0]         cpl_valid,
  input  logic [CPL_W*IDX_W-1:0]   cpl_idx,
  input  logic [CPL_W*PREG_W-1:0]  cpl_rd,
  input  logic [CPL_W*XLEN-1:0]    cpl_result,
  output logic [CPL_W-1:0]         fwd_valid,
  output logic [CPL_W*PREG_W-1:0]  fwd_reg,
  output logic [CPL_W*XLEN-1:0]    fwd_val,
  output logic [RET_W-1:0]         ret_valid,
  output logic [RET_W*XLEN-1:0]    ret_pc,
  output logic [RET_W*PREG_W-1:0]  ret_rd,
  output logic [RET_W*PREG_W-1:0]  ret_rd_old,
  output logic [RET_W*XLEN-1:0]    ret_result,
  output logic [RET_W-1:0]         ret_regwrite,
  output logic [IDX_W:0]           count
`ifdef ROB_FLUSH_EN
  ,
  input  logic                     flush,
  input  logic [IDX_W-1:0]         flush_idx
`endif
);

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d, acc_cnt, ret_cnt, sel_cnt;
  logic [DEPTH-1:0] ent_valid, ent_done;
  logic [RET_W-1:0] sel_valid;
  logic [IDX_W-1:0] cpl_slot, disp_slot, clr_slot, out_slot;
  logic             run;
  rob_fwd_t         fwd [CPL_W];

  assign count      = count_q;
  // Only registered occupancy counts; same-cycle retirement is not treated as free space.
  assign disp_ready = (count_q <= (IDX_W+1)'(DEPTH - DISP_W));
  assign ret_valid  = reset ? '0 : sel_valid;
  assign ret_cnt    = reset ? '0 : sel_cnt;

  always_comb begin
    fwd_valid = '0;
    fwd_reg   = '0;
    fwd_val   = '0;
    for (int p = 0; p < CPL_W; p++) begin
      fwd[p].valid = cpl_valid[p];
      fwd[p].preg  = cpl_valid[p] ? cpl_rd[p*PREG_W +: PREG_W] : '0;
      fwd[p].val   = cpl_valid[p] ? cpl_result[p*XLEN +: XLEN] : '0;
      fwd_valid[p]                 = fwd[p].valid;
      fwd_reg[p*PREG_W +: PREG_W]  = fwd[p].preg;
      fwd_val[p*XLEN +: XLEN]      = fwd[p].val;
    end
  end

  always_comb begin
    disp_idx = '0;
    acc_cnt  = '0;
    run      = 1'b1;
    for (int i = 0; i < DISP_W; i++) begin
      disp_idx[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
      if (run && disp_valid[i]) acc_cnt = acc_cnt + (IDX_W+1)'(1);
      else                      run     = 1'b0;
    end
    if (!disp_ready) acc_cnt = '0;
`ifdef ROB_FLUSH_EN
    if (flush) acc_cnt = '0;
`endif
  end

  always_comb begin
    ent_valid = '0;
    ent_done  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_valid[k] = entries_q[k].valid;
      ent_done[k]  = entries_q[k].done;
    end
  end

  rob_retire_select #(
    .DEPTH (DEPTH),
    .RET_W (RET_W),
    .IDX_W (IDX_W)
  ) u_retire_select (
    .head      (head_q),
    .count     (count_q),
    .ent_valid (ent_valid),
    .ent_done  (ent_done),
    .sel_valid (sel_valid),
    .sel_cnt   (sel_cnt)
  );

  always_comb begin
    ret_pc       = '0;
    ret_rd       = '0;
    ret_rd_old   = '0;
    ret_result   = '0;
    ret_regwrite = '0;
    out_slot     = '0;
    for (int j = 0; j < RET_W; j++) begin
      out_slot = head_q + IDX_W'(j);
      if (ret_valid[j]) begin
        ret_pc[j*XLEN +: XLEN]       = entries_q[out_slot].pc;
        ret_rd[j*PREG_W +: PREG_W]     = entries_q[out_slot].rd;
        ret_rd_old[j*PREG_W +: PREG_W] = entries_q[out_slot].rd_old;
        ret_result[j*XLEN +: XLEN]   = entries_q[out_slot].result;
        ret_regwrite[j]              = entries_q[out_slot].regwrite;
      end
    end
  end

  // Update order sets priority: completion (highest port last), then dispatch, retire, flush.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q + IDX_W'(ret_cnt);
    tail_d    = tail_q + IDX_W'(acc_cnt);
    count_d   = count_q + acc_cnt - ret_cnt;
    cpl_slot  = '0;
    disp_slot = '0;
    clr_slot  = '0;
    for (int p = 0; p < CPL_W; p++) begin
      cpl_slot = cpl_idx[p*IDX_W +: IDX_W];
      if (cpl_valid[p] && entries_q[cpl_slot].valid) begin
        entries_d[cpl_slot].done   = 1'b1;
        entries_d[cpl_slot].result = cpl_result[p*XLEN +: XLEN];
      end
    end
    for (int i = 0; i < DISP_W; i++) begin
      disp_slot = tail_q + IDX_W'(i);
      if ((IDX_W+1)'(i) < acc_cnt) begin
        entries_d[disp_slot].valid    = 1'b1;
        entries_d[disp_slot].done     = 1'b0;
        entries_d[disp_slot].pc       = disp_pc[i*XLEN +: XLEN];
        entries_d[disp_slot].rd       = disp_rd[i*PREG_W +: PREG_W];
        entries_d[disp_slot].rd_old   = disp_rd_old[i*PREG_W +: PREG_W];
        entries_d[disp_slot].result   = '0;
        entries_d[disp_slot].regwrite = disp_regwrite[i];
      end
    end
    for (int j = 0; j < RET_W; j++) begin
      clr_slot = head_q + IDX_W'(j);
      if (ret_valid[j]) begin
        entries_d[clr_slot].valid = 1'b0;
        entries_d[clr_slot].done  = 1'b0;
      end
    end
`ifdef ROB_FLUSH_EN
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((IDX_W'(k) - head_q) > (flush_idx - head_q)) begin
          entries_d[k].valid = 1'b0;
          entries_d[k].done  = 1'b0;
        end
      end
      tail_d  = flush_idx + IDX_W'(1);
      count_d = ({1'b0, flush_idx - head_q} + (IDX_W+1)'(1)) - ret_cnt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) entries_q[k] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) entries_q[k] <= entries_d[k];
    end
  end

endmodule

// File: tb/tb_rob_multi_port.sv
// Directed self-checking bench for rob_multi_port; flush steps build only with ROB_FLUSH_EN.
module tb_rob_multi_port;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DISP_W = 2;
  localparam int unsigned CPL_W  = 3;
  localparam int unsigned RET_W  = 2;
  localparam int unsigned PREG_W = 6;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned IDX_W  = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [DISP_W-1:0]        disp_valid;
  logic [DISP_W*XLEN-1:0]   disp_pc;
  logic [DISP_W*PREG_W-1:0] disp_rd;
  logic [DISP_W*PREG_W-1:0] disp_rd_old;
  logic [DISP_W-1:0]        disp_regwrite;
  logic                     disp_ready;
  logic [DISP_W*IDX_W-1:0]  disp_idx;
  logic [CPL_W-1:0]         cpl_valid;
  logic [CPL_W*IDX_W-1:0]   cpl_idx;
  logic [CPL_W*PREG_W-1:0]  cpl_rd;
  logic [CPL_W*XLEN-1:0]    cpl_result;
  logic [CPL_W-1:0]         fwd_valid;
  logic [CPL_W*PREG_W-1:0]  fwd_reg;
  logic [CPL_W*XLEN-1:0]    fwd_val;
  logic [RET_W-1:0]         ret_valid;
  logic [RET_W*XLEN-1:0]    ret_pc;
  logic [RET_W*PREG_W-1:0]  ret_rd;
  logic [RET_W*PREG_W-1:0]  ret_rd_old;
  logic [RET_W*XLEN-1:0]    ret_result;
  logic [RET_W-1:0]         ret_regwrite;
  logic [IDX_W:0]           count;
`ifdef ROB_FLUSH_EN
  logic                     flush;
  logic [IDX_W-1:0]         flush_idx;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_multi_port dut (
    .clk           (clk),
    .reset         (reset),
    .disp_valid    (disp_valid),
    .disp_pc       (disp_pc),
    .disp_rd       (disp_rd),
    .disp_rd_old   (disp_rd_old),
    .disp_regwrite (disp_regwrite),
    .disp_ready    (disp_ready),
    .disp_idx      (disp_idx),
    .cpl_valid     (cpl_valid),
    .cpl_idx       (cpl_idx),
    .cpl_rd        (cpl_rd),
    .cpl_result    (cpl_result),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_val       (fwd_val),
    .ret_valid     (ret_valid),
    .ret_pc        (ret_pc),
    .ret_rd        (ret_rd),
    .ret_rd_old    (ret_rd_old),
    .ret_result    (ret_result),
    .ret_regwrite  (ret_regwrite),
    .count         (count)
`ifdef ROB_FLUSH_EN
    ,
    .flush         (flush),
    .flush_idx     (flush_idx)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_valid = '0; disp_pc = '0; disp_rd = '0; disp_rd_old = '0; disp_regwrite = '0;
    cpl_valid = '0; cpl_idx = '0; cpl_rd = '0; cpl_result = '0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0; flush_idx = '0;
`endif
  endtask

  task automatic disp_lane(input int i, input logic [31:0] pc, input logic [5:0] rd,
                           input logic [5:0] rd_old, input logic rw);
    disp_valid[i]               = 1'b1;
    disp_pc[i*XLEN +: XLEN]     = pc;
    disp_rd[i*PREG_W +: PREG_W]     = rd;
    disp_rd_old[i*PREG_W +: PREG_W] = rd_old;
    disp_regwrite[i]            = rw;
  endtask

  task automatic cpl_port(input int p, input logic [3:0] idx, input logic [5:0] rd,
                          input logic [31:0] res);
    cpl_valid[p]               = 1'b1;
    cpl_idx[p*IDX_W +: IDX_W]  = idx;
    cpl_rd[p*PREG_W +: PREG_W] = rd;
    cpl_result[p*XLEN +: XLEN] = res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the wrap phase.
  logic [31:0] m_pc   [16];
  logic        m_done [16];
  logic [31:0] exp_q  [$];
  logic [31:0] exp_pc;
  logic [3:0]  m_head, m_tail, b, sc;
  logic [1:0]  exp_rv;
  int m_count, issued, retired, cyc, n_acc, nr, ncpl, lanes;

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_ret_valid", 64'(ret_valid), 64'd0);
    chk("rst_ret_pc", 64'(ret_pc), 64'd0);
    chk("rst_ret_result", 64'(ret_result), 64'd0);
    reset = 1'b0;

    // Two-lane dispatch
    disp_lane(0, 32'h100, 6'd1, 6'd11, 1'b1);
    disp_lane(1, 32'h104, 6'd2, 6'd12, 1'b0);
    #1;
    chk("disp_idx_01", 64'(disp_idx), 64'h10);
    step(); idle(); #1;
    chk("count_2", 64'(count), 64'd2);
    chk("ret_none_after_disp", 64'(ret_valid), 64'd0);

    cpl_port(0, 4'd1, 6'd2, 32'hAA);
    #1;
    chk("fwd_valid_p0", 64'(fwd_valid), 64'b001);
    chk("fwd_reg_p0", 64'(fwd_reg), 64'd2);
    chk("fwd_val_p0", 64'(fwd_val[31:0]), 64'hAA);
    chk("fwd_val_p2_idle", 64'(fwd_val[95:64]), 64'd0);
    step(); idle(); #1;
    chk("ret_wait_head", 64'(ret_valid), 64'd0);

    cpl_port(2, 4'd0, 6'd1, 32'h55);
    #1;
    chk("fwd_valid_p2", 64'(fwd_valid), 64'b100);
    chk("fwd_reg_p2", 64'(fwd_reg[17:12]), 64'd1);
    chk("fwd_val_p2", 64'(fwd_val[95:64]), 64'h55);
    chk("fwd_val_p0_idle", 64'(fwd_val[31:0]), 64'd0);
    chk("no_cpl_bypass", 64'(ret_valid), 64'd0);
    step(); idle(); #1;
    chk("ret_pair_valid", 64'(ret_valid), 64'b11);
    chk("ret_pair_pc", ret_pc, 64'h00000104_00000100);
    chk("ret_pair_result", ret_result, 64'h000000AA_00000055);
    chk("ret_pair_rd", 64'(ret_rd), 64'h081);
    chk("ret_pair_rd_old", 64'(ret_rd_old), 64'h30B);
    chk("ret_pair_regwrite", 64'(ret_regwrite), 64'b01);
    step(); #1;
    chk("count_after_ret", 64'(count), 64'd0);
    chk("ret_idle_empty", 64'(ret_valid), 64'd0);

    // Fill to full: head = tail = 2
    for (int k = 0; k < 8; k++) begin
      idle();
      disp_lane(0, 32'h200 + 32'(8*k), 6'd3, 6'd4, 1'b1);
      disp_lane(1, 32'h204 + 32'(8*k), 6'd5, 6'd6, 1'b1);
      step();
    end
    idle(); #1;
    chk("full_count", 64'(count), 64'd16);
    chk("full_not_ready", 64'(disp_ready), 64'd0);
    disp_lane(0, 32'h999, 6'd7, 6'd8, 1'b1);
    #1;
    chk("full_tail", 64'(disp_idx[3:0]), 64'd2);
    step(); idle(); #1;
    chk("drop_17th", 64'(count), 64'd16);
    cpl_port(0, 4'd2, 6'd3, 32'h1);
    cpl_port(1, 4'd3, 6'd5, 32'h2);
    step(); idle(); #1;
    chk("full_ret_valid", 64'(ret_valid), 64'b11);
    chk("full_ret_pc", ret_pc, 64'h00000204_00000200);
    chk("ready_uses_reg_count", 64'(disp_ready), 64'd0);
    step(); #1;
    chk("count_14", 64'(count), 64'd14);
    chk("ready_again", 64'(disp_ready), 64'd1);

    // Wrap phase: 14 live entries at idx 4..1 plus 40 new instructions
    m_head = 4'd4; m_tail = 4'd2; m_count = 14;
    for (int k = 0; k < 16; k++) m_done[k] = 1'b0;
    for (int n = 0; n < 14; n++) begin
      m_pc[(4 + n) % 16] = 32'h208 + 32'(4*n);
      exp_q.push_back(32'h208 + 32'(4*n));
    end
    issued = 0; retired = 0; cyc = 0;
    while (retired < 54 && cyc < 400) begin
      idle();
      lanes = 0;
      for (int i = 0; i < 2; i++) begin
        if (issued + i < 40) begin
          disp_lane(i, 32'h1000 + 32'(4*(issued + i)), 6'd9, 6'd10, 1'b1);
          lanes++;
        end
      end
      n_acc = (m_count <= 14) ? lanes : 0;
      ncpl = 0;
      if (cyc % 3 != 0) begin
        for (int n = 0; n < m_count; n++) begin
          sc = m_head + 4'(n);
          if (!m_done[sc] && ncpl < 2) begin
            cpl_port(ncpl * 2, sc, 6'd9, m_pc[sc] ^ 32'hFFFF);
            ncpl++;
          end
        end
      end
      exp_rv = 2'b00;
      if (m_count > 0 && m_done[m_head]) begin
        exp_rv[0] = 1'b1;
        if (m_count > 1 && m_done[m_head + 4'd1]) exp_rv[1] = 1'b1;
      end
      #1;
      chk("wrap_ret_valid", 64'(ret_valid), 64'(exp_rv));
      nr = 0;
      for (int j = 0; j < 2; j++) begin
        if (exp_rv[j] && exp_q.size() > 0) begin
          exp_pc = exp_q.pop_front();
          chk("wrap_ret_pc", 64'(ret_pc[j*XLEN +: XLEN]), 64'(exp_pc));
          chk("wrap_ret_result", 64'(ret_result[j*XLEN +: XLEN]), 64'(exp_pc ^ 32'hFFFF));
          nr++;
        end
      end
      step();
      for (int j = 0; j < nr; j++) m_done[m_head + 4'(j)] = 1'b0;
      m_head = m_head + 4'(nr);
      for (int p = 0; p < CPL_W; p++)
        if (cpl_valid[p]) m_done[cpl_idx[p*IDX_W +: IDX_W]] = 1'b1;
      for (int i = 0; i < n_acc; i++) begin
        m_pc[m_tail]   = 32'h1000 + 32'(4*(issued + i));
        m_done[m_tail] = 1'b0;
        exp_q.push_back(m_pc[m_tail]);
        m_tail = m_tail + 4'd1;
      end
      issued  = issued + n_acc;
      m_count = m_count + n_acc - nr;
      retired = retired + nr;
      cyc++;
    end
    idle(); #1;
    chk("wrap_all_retired", 64'(retired), 64'd54);
    chk("wrap_count_zero", 64'(count), 64'd0);
    chk("wrap_tail", 64'(disp_idx[3:0]), 64'd10);

    // Same-cycle dispatch/complete/retire from idx 10
    b = m_tail;
    for (int k = 0; k < 3; k++) begin
      idle();
      disp_lane(0, 32'h3000 + 32'(8*k), 6'd1, 6'd2, 1'b1);
      disp_lane(1, 32'h3004 + 32'(8*k), 6'd3, 6'd4, 1'b1);
      step();
    end
    idle();
    cpl_port(0, b, 6'd1, 32'h11);
    cpl_port(1, b, 6'd1, 32'h22);
    cpl_port(2, b + 4'd1, 6'd3, 32'h33);
    step(); idle();
    disp_lane(0, 32'h3018, 6'd1, 6'd2, 1'b1);
    disp_lane(1, 32'h301C, 6'd3, 6'd4, 1'b1);
    cpl_port(0, b + 4'd2, 6'd1, 32'h44);
    cpl_port(1, b + 4'd3, 6'd3, 32'h45);
    cpl_port(2, b + 4'd4, 6'd1, 32'h46);
    #1;
    chk("same_cycle_count_before", 64'(count), 64'd6);
    chk("same_cycle_ret_valid", 64'(ret_valid), 64'b11);
    chk("same_cycle_ret_pc", ret_pc, 64'h00003004_00003000);
    chk("port1_wins", ret_result, 64'h00000033_00000022);
    step(); idle(); #1;
    chk("same_cycle_count_after", 64'(count), 64'd6);
    chk("next_ret_pc", ret_pc, 64'h0000300C_00003008);

    // Reset with live, retirable entries
    reset = 1'b1;
    #1;
    chk("reset_no_retire", 64'(ret_valid), 64'd0);
    chk("reset_ret_pc_zero", 64'(ret_pc), 64'd0);
    step();
    chk("reset_count", 64'(count), 64'd0);
    reset = 1'b0;
    step();
    chk("post_reset_count", 64'(count), 64'd0);
    chk("post_reset_ret", 64'(ret_valid), 64'd0);

`ifdef ROB_FLUSH_EN
    for (int k = 0; k < 3; k++) begin
      idle();
      disp_lane(0, 32'h4000 + 32'(8*k), 6'd1, 6'd2, 1'b1);
      disp_lane(1, 32'h4004 + 32'(8*k), 6'd3, 6'd4, 1'b1);
      step();
    end
    idle();
    flush = 1'b1;
    flush_idx = 4'd2;
    step(); idle(); #1;
    chk("flush_count", 64'(count), 64'd3);
    chk("flush_tail", 64'(disp_idx[3:0]), 64'd3);
    cpl_port(0, 4'd0, 6'd1, 32'h70);
    cpl_port(1, 4'd1, 6'd3, 32'h71);
    cpl_port(2, 4'd2, 6'd1, 32'h72);
    step(); idle();
    cpl_port(0, 4'd3, 6'd1, 32'h73);
    cpl_port(1, 4'd4, 6'd3, 32'h74);
    cpl_port(2, 4'd5, 6'd1, 32'h75);
    #1;
    chk("flush_ret0_valid", 64'(ret_valid), 64'b11);
    chk("flush_ret0_pc", ret_pc, 64'h00004004_00004000);
    step(); idle(); #1;
    chk("flush_ret1_valid", 64'(ret_valid), 64'b01);
    chk("flush_ret1_pc", 64'(ret_pc[31:0]), 64'h4008);
    step(); #1;
    chk("flush_empty", 64'(count), 64'd0);
    chk("flushed_never_retire", 64'(ret_valid), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
